// File: rtl/regfile_mp.sv
// Multi-port register file with three read ports, two write ports and a per-register load-pending scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module regfile_mp #(
    parameter int  DATA_W = 32,
    parameter int  NREG   = 16,
    localparam int ADDR_W = $clog2(NREG),
    parameter int  PC_IDX = NREG - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we4,
    input  logic [ADDR_W-1:0] wa4,
    input  logic [DATA_W-1:0] wd4,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra3,
    input  logic [DATA_W-1:0] r15,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    input  logic              flush,
    output logic              rd1_busy,
    output logic              rd2_busy,
    output logic              rd3_busy
);

    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0] regs_r [NREG];
    logic [NREG-1:0]   pending_r;
    logic [NREG-1:0]   pending_nxt_s;

    // Returns {busy, data} for one read port; the PC alias never reports pending.
`ifdef REGFILE_WRITE_BYPASS_EN
    function automatic logic [DATA_W:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              stored_busy,
        input logic              w3_en,
        input logic [ADDR_W-1:0] w3_addr,
        input logic [DATA_W-1:0] w3_data,
        input logic              w4_en,
        input logic [ADDR_W-1:0] w4_addr,
        input logic [DATA_W-1:0] w4_data,
        input logic [DATA_W-1:0] pc_val
    );
        logic [DATA_W:0] res;
        if (ra == PC_A) begin
            res = {1'b0, pc_val};
        end else if (w4_en && (w4_addr == ra)) begin
            // Load writeback is the youngest producer and also resolves the pending load.
            res = {1'b0, w4_data};
        end else if (w3_en && (w3_addr == ra)) begin
            res = {stored_busy, w3_data};
        end else begin
            res = {stored_busy, stored};
        end
        return res;
    endfunction
`else
    function automatic logic [DATA_W:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              stored_busy,
        input logic [DATA_W-1:0] pc_val
    );
        logic [DATA_W:0] res;
        if (ra == PC_A) begin
            res = {1'b0, pc_val};
        end else begin
            res = {stored_busy, stored};
        end
        return res;
    endfunction
`endif

    // Register storage: port 4 wins a same-address conflict; the PC slot is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (i != PC_IDX) begin
                    if (we4 && (wa4 == ADDR_W'(i))) begin
                        regs_r[i] <= wd4;
                    end else if (we3 && (wa3 == ADDR_W'(i))) begin
                        regs_r[i] <= wd3;
                    end
                end
            end
        end
    end

    // Scoreboard next state: flush dominates, and a new load outranks its own register's writeback.
    always_comb begin
        pending_nxt_s = pending_r;
        if (flush) begin
            pending_nxt_s = {NREG{1'b0}};
        end else begin
            if (we4) begin
                pending_nxt_s[wa4] = 1'b0;
            end else begin
                pending_nxt_s = pending_nxt_s;
            end
            if (busy_set) begin
                pending_nxt_s[busy_addr] = 1'b1;
            end else begin
                pending_nxt_s = pending_nxt_s;
            end
        end
        pending_nxt_s[PC_IDX] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= {NREG{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Combinational read ports.
    always_comb begin
`ifdef REGFILE_WRITE_BYPASS_EN
        {rd1_busy, rd1} = read_port(ra1, regs_r[ra1], pending_r[ra1], we3, wa3, wd3, we4, wa4, wd4, r15);
        {rd2_busy, rd2} = read_port(ra2, regs_r[ra2], pending_r[ra2], we3, wa3, wd3, we4, wa4, wd4, r15);
        {rd3_busy, rd3} = read_port(ra3, regs_r[ra3], pending_r[ra3], we3, wa3, wd3, we4, wa4, wd4, r15);
`else
        {rd1_busy, rd1} = read_port(ra1, regs_r[ra1], pending_r[ra1], r15);
        {rd2_busy, rd2} = read_port(ra2, regs_r[ra2], pending_r[ra2], r15);
        {rd3_busy, rd3} = read_port(ra3, regs_r[ra3], pending_r[ra3], r15);
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp (16 x 32-bit configuration).
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        we3, we4, busy_set, flush;
    logic [3:0]  wa3, wa4, ra1, ra2, ra3, busy_addr;
    logic [31:0] wd3, wd4, r15;
    logic [31:0] rd1, rd2, rd3;
    logic        rd1_busy, rd2_busy, rd3_busy;

    int total = 0;
    int bad   = 0;

    regfile_mp #(.DATA_W(32), .NREG(16)) dut (
        .clk(clk), .reset(reset),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .ra1(ra1), .ra2(ra2), .ra3(ra3), .r15(r15),
        .rd1(rd1), .rd2(rd2), .rd3(rd3),
        .busy_set(busy_set), .busy_addr(busy_addr), .flush(flush),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy), .rd3_busy(rd3_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we3;
        logic [3:0]  wa3;
        logic [31:0] wd3;
        logic        we4;
        logic [3:0]  wa4;
        logic [31:0] wd4;
        logic        bs;
        logic [3:0]  ba;
        logic        fl;
        logic [3:0]  a1, a2, a3;
        logic [31:0] e1, e2, e3;
        logic [2:0]  eb;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    function automatic vec_t mk(
        input logic w3, input logic [3:0] a_w3, input logic [31:0] d3,
        input logic w4, input logic [3:0] a_w4, input logic [31:0] d4,
        input logic bs, input logic [3:0] ba, input logic fl,
        input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
        input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
        input logic [2:0] eb);
        vec_t v;
        v.we3 = w3; v.wa3 = a_w3; v.wd3 = d3;
        v.we4 = w4; v.wa4 = a_w4; v.wd4 = d4;
        v.bs = bs; v.ba = ba; v.fl = fl;
        v.a1 = a1; v.a2 = a2; v.a3 = a3;
        v.e1 = e1; v.e2 = e2; v.e3 = e3; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we3 = 1'b0; wa3 = 4'd0; wd3 = 32'h0;
        we4 = 1'b0; wa4 = 4'd0; wd4 = 32'h0;
        busy_set = 1'b0; busy_addr = 4'd0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        r15 = 32'hCAFEBABE;
        ra1 = 4'd0; ra2 = 4'd15; ra3 = 4'd0;
        idle_inputs();

        // eb bits are {rd1_busy, rd2_busy, rd3_busy}
        vt[0]  = mk(1'b1, 4'd1,  32'h12345678, 1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  1'b0, 4'd1,  4'd1, 4'd1,  32'h12345678, 32'h12345678, 32'h12345678, 3'b000);
        vt[1]  = mk(1'b1, 4'd2,  32'h87654321, 1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  1'b0, 4'd1,  4'd2, 4'd1,  32'h12345678, 32'h87654321, 32'h12345678, 3'b000);
        vt[2]  = mk(1'b1, 4'd5,  32'h11111111, 1'b1, 4'd5,  32'h22222222, 1'b0, 4'd0,  1'b0, 4'd5,  4'd1, 4'd2,  32'h22222222, 32'h12345678, 32'h87654321, 3'b000);
        vt[3]  = mk(1'b1, 4'd15, 32'hDEADBEEF, 1'b1, 4'd15, 32'h01020304, 1'b0, 4'd0,  1'b0, 4'd15, 4'd15, 4'd5, 32'hCAFEBABE, 32'hCAFEBABE, 32'h22222222, 3'b000);
        vt[4]  = mk(1'b1, 4'd6,  32'hAAAA0006, 1'b1, 4'd7,  32'hBBBB0007, 1'b0, 4'd0,  1'b0, 4'd6,  4'd7, 4'd5,  32'hAAAA0006, 32'hBBBB0007, 32'h22222222, 3'b000);
        vt[5]  = mk(1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd3,  1'b0, 4'd3,  4'd4, 4'd15, 32'h0,        32'h0,        32'hCAFEBABE, 3'b100);
        vt[6]  = mk(1'b0, 4'd0,  32'h0,        1'b1, 4'd3,  32'hABCDEF00, 1'b0, 4'd0,  1'b0, 4'd3,  4'd4, 4'd0,  32'hABCDEF00, 32'h0,        32'h0,        3'b000);
        vt[7]  = mk(1'b0, 4'd0,  32'h0,        1'b1, 4'd4,  32'h44440004, 1'b1, 4'd4,  1'b0, 4'd4,  4'd3, 4'd4,  32'h44440004, 32'hABCDEF00, 32'h44440004, 3'b101);
        vt[8]  = mk(1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd15, 1'b0, 4'd15, 4'd4, 4'd3,  32'hCAFEBABE, 32'h44440004, 32'hABCDEF00, 3'b010);
        vt[9]  = mk(1'b1, 4'd9,  32'h99999999, 1'b0, 4'd0,  32'h0,        1'b1, 4'd9,  1'b0, 4'd9,  4'd4, 4'd6,  32'h99999999, 32'h44440004, 32'hAAAA0006, 3'b110);
        vt[10] = mk(1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd6,  1'b0, 4'd6,  4'd9, 4'd4,  32'hAAAA0006, 32'h99999999, 32'h44440004, 3'b111);
        vt[11] = mk(1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd7,  1'b0, 4'd7,  4'd6, 4'd9,  32'hBBBB0007, 32'hAAAA0006, 32'h99999999, 3'b111);
        vt[12] = mk(1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd8,  1'b1, 4'd6,  4'd7, 4'd8,  32'hAAAA0006, 32'hBBBB0007, 32'h0,        3'b000);
        vt[13] = mk(1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  1'b0, 4'd4,  4'd9, 4'd3,  32'h44440004, 32'h99999999, 32'hABCDEF00, 3'b000);
        vt[14] = mk(1'b0, 4'd0,  32'h0,        1'b1, 4'd12, 32'h12121212, 1'b0, 4'd0,  1'b1, 4'd12, 4'd7, 4'd3,  32'h12121212, 32'hBBBB0007, 32'hABCDEF00, 3'b000);

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd1_addr0", rd1, 32'h0);
        check("rst_rd2_pc", rd2, 32'hCAFEBABE);
        check("rst_rd3_addr0", rd3, 32'h0);
        check("rst_busy", {29'd0, rd1_busy, rd2_busy, rd3_busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            we3 = vt[i].we3; wa3 = vt[i].wa3; wd3 = vt[i].wd3;
            we4 = vt[i].we4; wa4 = vt[i].wa4; wd4 = vt[i].wd4;
            busy_set = vt[i].bs; busy_addr = vt[i].ba; flush = vt[i].fl;
            @(posedge clk);
            #1;
            idle_inputs();
            ra1 = vt[i].a1; ra2 = vt[i].a2; ra3 = vt[i].a3;
            #1;
            check($sformatf("v%0d_rd1", i), rd1, vt[i].e1);
            check($sformatf("v%0d_rd2", i), rd2, vt[i].e2);
            check($sformatf("v%0d_rd3", i), rd3, vt[i].e3);
            check($sformatf("v%0d_busy", i), {29'd0, rd1_busy, rd2_busy, rd3_busy}, {29'd0, vt[i].eb});
        end

        // Same-cycle read of an in-flight write to a pending register.
        @(negedge clk);
        busy_set = 1'b1; busy_addr = 4'd1;
        @(posedge clk);
        #1;
        idle_inputs();
        we3 = 1'b1; wa3 = 4'd1; wd3 = 32'hFFFF0001;
        we4 = 1'b1; wa4 = 4'd1; wd4 = 32'hEEEE0001;
        ra1 = 4'd1;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("byp_rd1_p4", rd1, 32'hEEEE0001);
        check("byp_busy_p4", {31'd0, rd1_busy}, 32'h0);
        we4 = 1'b0;
        #1;
        check("byp_rd1_p3", rd1, 32'hFFFF0001);
        check("byp_busy_p3", {31'd0, rd1_busy}, 32'h1);
`else
        check("nobyp_rd1", rd1, 32'h12345678);
        check("nobyp_busy", {31'd0, rd1_busy}, 32'h1);
`endif
        idle_inputs();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("post_flush_rd1", rd1, 32'h12345678);
        check("post_flush_busy", {31'd0, rd1_busy}, 32'h0);

        // Reset asserted mid-write and mid-busy_set.
        @(negedge clk);
        we3 = 1'b1; wa3 = 4'd9; wd3 = 32'h55AA55AA;
        busy_set = 1'b1; busy_addr = 4'd10;
        ra1 = 4'd9; ra2 = 4'd10; ra3 = 4'd6;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("byp_midrst_rd1", rd1, 32'h55AA55AA);
`else
        check("midrst_pre_rd1", rd1, 32'h99999999);
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("midrst_rd1", rd1, 32'h0);
        check("midrst_rd3", rd3, 32'h0);
        check("midrst_busy2", {31'd0, rd2_busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("after_rst_rd1", rd1, 32'h0);
        check("after_rst_busy2", {31'd0, rd2_busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
